apb_master_if: RTL and testbench
================================

Name: apb_master_if

Overview:
- APB initiator (requester) bridge. Accepts single read/write commands on a valid/ready command port and executes each as one APB transfer (SETUP, then ACCESS with wait states).
- Returns read data and error/timeout status on a valid/ready response port.
- Sits between a local controller (sequencer, DMA, test master) and the APB peripheral bus, e.g. the timer register slaves.

Parameters:
- ADR_W, 32, address width of CMD_ADDR and PADDR.
- DAT_W, 32, data width of write/read data.
- TOUT_W, 16, width of the wait-state timeout counter and of TOUT_CYC.

Ports:
- PCLK  in  1  APB clock; all logic is posedge.
- PRESETn  in  1  asynchronous active-low reset.
- TOUT_CYC  in  TOUT_W  max ACCESS cycles with PREADY=0 before abort; 0 = timeout disabled.
- CMD_VALID  in  1  command request.
- CMD_READY  out  1  command accepted when VALID&READY.
- CMD_WRITE  in  1  1=write, 0=read.
- CMD_ADDR  in  ADR_W  byte address.
- CMD_WDATA  in  DAT_W  write data.
- RSP_VALID  out  1  response available.
- RSP_READY  in  1  response consumed when VALID&READY.
- RSP_RDATA  out  DAT_W  read data (0 for writes, errors and timeouts).
- RSP_ERR  out  1  PSLVERR seen or timeout.
- RSP_TOUT  out  1  transfer aborted by timeout.
- PADDR  out  ADR_W  APB address.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB direction.
- PWDATA  out  DAT_W  APB write data.
- PREADY  in  1  slave ready.
- PRDATA  in  DAT_W  slave read data.
- PSLVERR  in  1  slave error.

Behaviour:
- Reset (async, PRESETn=0), all outputs 0: state=IDLE, PSEL=PENABLE=PWRITE=0, PADDR=0, PWDATA=0, RSP_*=0, timeout counter=0. CMD_READY=1 one cycle after reset release.
- Reset mid-transfer: bus is dropped immediately (PSEL=0); the command and its response are lost.
- All APB and RSP outputs are registered. CMD_READY is decoded from state (1 only in IDLE).
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE: on CMD_VALID, capture PADDR<=CMD_ADDR and PWRITE<=CMD_WRITE. Capture PWDATA<=CMD_WDATA if write, else 0. Go to SETUP.
- SETUP: PSEL=1, PENABLE=0. Unconditionally go to ACCESS next cycle.
- ACCESS: PSEL=1, PENABLE=1.
  - PREADY=1: latch RSP_ERR<=PSLVERR and RSP_TOUT<=0. Latch RSP_RDATA<=PRDATA only if read and PSLVERR=0, else 0. Go to RESP.
  - PREADY=0: increment wait counter. If TOUT_CYC!=0 and the counter reaches TOUT_CYC, abort: RSP_ERR=1, RSP_TOUT=1, RSP_RDATA=0, go to RESP.
  - The counter clears on entering SETUP.
- RESP: PSEL=PENABLE=0, RSP_VALID=1, response fields held stable. On RSP_READY, go to IDLE and clear RSP_VALID.
- PADDR, PWRITE and PWDATA hold their last values outside a transfer. They are stable from SETUP through end of ACCESS.
- Latency, zero wait states: command accepted at cycle 0, SETUP at cycle 1, ACCESS at cycle 2, RSP_VALID at cycle 3.
- Back-to-back minimum period: 4 cycles per command if RSP_READY is held high.
- No overlap: a new command is not accepted while a response is pending.
- Timeout boundaries:
  - TOUT_CYC=1 aborts after the first ACCESS cycle with PREADY=0.
  - PREADY=1 in the same cycle the counter would hit the limit: the completion wins, no timeout.
  - The counter saturates and does not wrap.
- TOUT_CYC is sampled every cycle. Software changes it only while idle.

Decomposition:
- Shared package apb_pkg: FSM state encoding (IDLE=2'd0, SETUP=2'd1, ACCESS=2'd2, RESP=2'd3) and default ADR_W/DAT_W constants, reused by the APB slave register blocks.
- One sub-module, apb_wait_timer: the saturating TOUT_W counter with clear/enable/limit compare, outputting tout_hit.

Test Plan:
- Write, PREADY=1: CMD addr=0x0000_0004, wdata=0x0000_1234. Expect PSEL at cycle 1, PENABLE at cycle 2, PWRITE=1, PWDATA=0x1234, then RSP_VALID at cycle 3 with ERR=0 and RDATA=0.
- Read, 3 wait states: slave returns PRDATA=0xDEAD_BEEF after PREADY has been low for 3 cycles. Expect ACCESS to last 4 cycles with PADDR/PWRITE stable, and RSP_RDATA=0xDEAD_BEEF with ERR=0.
- Slave error: read with PSLVERR=1 and PRDATA=0xFFFF_FFFF. Expect RSP_ERR=1, RSP_TOUT=0, RSP_RDATA=0.
- Timeout: TOUT_CYC=5 with PREADY stuck at 0. Expect abort after 5 ACCESS cycles, PSEL=0, then RSP_ERR=1, RSP_TOUT=1. Also TOUT_CYC=0 with PREADY delayed 100 cycles: completes normally.
- Backpressure and back-to-back: RSP_READY=0 for 4 cycles while CMD_VALID stays high. Expect CMD_READY=0 and response held stable. Then with RSP_READY=1, two commands complete 4 cycles apart.
- Reset mid-ACCESS: assert PRESETn=0 during a wait state. Expect all outputs 0 asynchronously, and CMD_READY=1 in the first cycle after release.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM state encoding and default bus widths,
// used by the master bridge and the APB slave register blocks.
`timescale 1ns/1ps
package apb_pkg;

  localparam int APB_ADR_W = 32;
  localparam int APB_DAT_W = 32;

  typedef enum logic [1:0] {
    APB_IDLE   = 2'd0,
    APB_SETUP  = 2'd1,
    APB_ACCESS = 2'd2,
    APB_RESP   = 2'd3
  } apb_state_e;

endpackage

// File: rtl/apb_wait_timer.sv
// Saturating wait-state counter for the ACCESS phase. tout_hit_o flags the
// cycle whose increment brings the count up to a non-zero limit, so the FSM
// can abort on that same edge.
`timescale 1ns/1ps
module apb_wait_timer #(
  parameter int TOUT_W = 16
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic [TOUT_W-1:0] limit_i,
  output logic              tout_hit_o
);

  logic [TOUT_W-1:0] cnt_q, cnt_d;

  // Next count: clear wins, otherwise count up and stick at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (en_i && (cnt_q != '1))
      cnt_d = cnt_q + TOUT_W'(1);
  end

  // A limit of zero disables the abort; >= keeps it safe if the limit shrinks.
  assign tout_hit_o = en_i && !clr_i && (limit_i != '0) && (cnt_d >= limit_i);

  // Counter register.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/apb_master_if.sv
// APB requester bridge: runs one SETUP/ACCESS transfer per accepted command
// and returns read data plus error/timeout status on a valid/ready port.
`timescale 1ns/1ps
module apb_master_if
  import apb_pkg::*;
#(
  parameter int ADR_W  = APB_ADR_W,
  parameter int DAT_W  = APB_DAT_W,
  parameter int TOUT_W = 16
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic [TOUT_W-1:0] TOUT_CYC,
  input  logic              CMD_VALID,
  output logic              CMD_READY,
  input  logic              CMD_WRITE,
  input  logic [ADR_W-1:0]  CMD_ADDR,
  input  logic [DAT_W-1:0]  CMD_WDATA,
  output logic              RSP_VALID,
  input  logic              RSP_READY,
  output logic [DAT_W-1:0]  RSP_RDATA,
  output logic              RSP_ERR,
  output logic              RSP_TOUT,
  output logic [ADR_W-1:0]  PADDR,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [DAT_W-1:0]  PWDATA,
  input  logic              PREADY,
  input  logic [DAT_W-1:0]  PRDATA,
  input  logic              PSLVERR
);

  apb_state_e       state_q;
  logic             live_q;     // low during reset and its first cycle out
  logic [ADR_W-1:0] paddr_q;
  logic             pwrite_q;
  logic [DAT_W-1:0] pwdata_q;
  logic             psel_q;
  logic             penable_q;
  logic             rsp_valid_q;
  logic [DAT_W-1:0] rsp_rdata_q;
  logic             rsp_err_q;
  logic             rsp_tout_q;
  logic             tout_hit;
  logic             cmd_acc;

  // Ready is a pure state decode, gated so it stays 0 while in reset.
  assign CMD_READY = (state_q == APB_IDLE) && live_q;
  assign cmd_acc   = CMD_VALID && CMD_READY;

  // Counter restarts on every accepted command, counts ACCESS wait cycles.
  apb_wait_timer #(.TOUT_W(TOUT_W)) u_timer (
    .PCLK       (PCLK),
    .PRESETn    (PRESETn),
    .clr_i      (cmd_acc),
    .en_i       ((state_q == APB_ACCESS) && !PREADY),
    .limit_i    (TOUT_CYC),
    .tout_hit_o (tout_hit)
  );

  // Transfer FSM with all APB and response outputs registered.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q     <= APB_IDLE;
      live_q      <= 1'b0;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      rsp_tout_q  <= 1'b0;
    end else begin
      live_q <= 1'b1;
      case (state_q)
        APB_IDLE: begin
          if (cmd_acc) begin
            paddr_q   <= CMD_ADDR;
            pwrite_q  <= CMD_WRITE;
            pwdata_q  <= CMD_WRITE ? CMD_WDATA : '0;
            psel_q    <= 1'b1;
            penable_q <= 1'b0;
            state_q   <= APB_SETUP;
          end
        end
        APB_SETUP: begin
          penable_q <= 1'b1;
          state_q   <= APB_ACCESS;
        end
        APB_ACCESS: begin
          // Completion is checked first so PREADY beats a same-cycle timeout.
          if (PREADY) begin
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= PSLVERR;
            rsp_tout_q  <= 1'b0;
            rsp_rdata_q <= (!pwrite_q && !PSLVERR) ? PRDATA : '0;
            state_q     <= APB_RESP;
          end else if (tout_hit) begin
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            rsp_tout_q  <= 1'b1;
            rsp_rdata_q <= '0;
            state_q     <= APB_RESP;
          end
        end
        APB_RESP: begin
          if (RSP_READY) begin
            rsp_valid_q <= 1'b0;
            state_q     <= APB_IDLE;
          end
        end
        default: state_q <= APB_IDLE;
      endcase
    end
  end

  assign PADDR     = paddr_q;
  assign PWRITE    = pwrite_q;
  assign PWDATA    = pwdata_q;
  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign RSP_VALID = rsp_valid_q;
  assign RSP_RDATA = rsp_rdata_q;
  assign RSP_ERR   = rsp_err_q;
  assign RSP_TOUT  = rsp_tout_q;

endmodule

// File: tb/tb_apb_master_if.sv
// Directed bench for apb_master_if: inputs driven and outputs sampled on the
// falling edge, one task per scenario, hand-computed expectations.
`timescale 1ns/1ps
module tb_apb_master_if;

  localparam int ADR_W  = 32;
  localparam int DAT_W  = 32;
  localparam int TOUT_W = 16;

  logic              PCLK = 1'b0;
  logic              PRESETn;
  logic [TOUT_W-1:0] TOUT_CYC;
  logic              CMD_VALID, CMD_READY, CMD_WRITE;
  logic [ADR_W-1:0]  CMD_ADDR;
  logic [DAT_W-1:0]  CMD_WDATA;
  logic              RSP_VALID, RSP_READY, RSP_ERR, RSP_TOUT;
  logic [DAT_W-1:0]  RSP_RDATA;
  logic [ADR_W-1:0]  PADDR;
  logic              PSEL, PENABLE, PWRITE;
  logic [DAT_W-1:0]  PWDATA;
  logic              PREADY, PSLVERR;
  logic [DAT_W-1:0]  PRDATA;

  logic [102:0] all_o;
  assign all_o = {CMD_READY, RSP_VALID, RSP_RDATA, RSP_ERR, RSP_TOUT,
                  PADDR, PSEL, PENABLE, PWRITE, PWDATA};

  int n_chk  = 0;
  int n_fail = 0;

  apb_master_if #(.ADR_W(ADR_W), .DAT_W(DAT_W), .TOUT_W(TOUT_W)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .TOUT_CYC(TOUT_CYC),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_WRITE(CMD_WRITE),
    .CMD_ADDR(CMD_ADDR), .CMD_WDATA(CMD_WDATA),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_RDATA(RSP_RDATA),
    .RSP_ERR(RSP_ERR), .RSP_TOUT(RSP_TOUT),
    .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PWDATA(PWDATA), .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge PCLK);
  endtask

  // Presents a command at the current falling edge; returns at the SETUP edge.
  task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] d);
    CMD_VALID = 1'b1; CMD_WRITE = wr; CMD_ADDR = a; CMD_WDATA = d;
    step();
    CMD_VALID = 1'b0;
  endtask

  // Consumes the pending response.
  task automatic drain();
    RSP_READY = 1'b1;
    step();
    RSP_READY = 1'b0;
  endtask

  task automatic test_reset();
    PRESETn = 1'b0; TOUT_CYC = '0; CMD_VALID = 0; CMD_WRITE = 0; CMD_ADDR = '0;
    CMD_WDATA = '0; RSP_READY = 0; PREADY = 0; PRDATA = '0; PSLVERR = 0;
    #12;
    n_chk++;
    if (all_o !== '0) begin n_fail++; $display("FAIL reset_outputs: got %h exp 0", all_o); end
    step();
    PRESETn = 1'b1;
    #1;
    n_chk++;
    if (CMD_READY !== 1'b0) begin n_fail++; $display("FAIL reset_release_ready: got %b exp 0", CMD_READY); end
    step();
    n_chk++;
    if (CMD_READY !== 1'b1) begin n_fail++; $display("FAIL reset_first_cycle_ready: got %b exp 1", CMD_READY); end
  endtask

  task automatic test_write();
    TOUT_CYC = '0; PREADY = 1'b1; PSLVERR = 1'b0; RSP_READY = 1'b0;
    issue(1'b1, 32'h0000_0004, 32'h0000_1234);
    n_chk++;
    if ({PSEL, PENABLE, PWRITE, CMD_READY} !== 4'b1010) begin
      n_fail++; $display("FAIL write_setup_ctl: got %b exp 1010", {PSEL, PENABLE, PWRITE, CMD_READY});
    end
    n_chk++;
    if ({PADDR, PWDATA} !== {32'h4, 32'h1234}) begin
      n_fail++; $display("FAIL write_setup_addr_data: got %h %h exp 4 1234", PADDR, PWDATA);
    end
    step();
    n_chk++;
    if ({PSEL, PENABLE, RSP_VALID} !== 3'b110) begin
      n_fail++; $display("FAIL write_access: got %b exp 110", {PSEL, PENABLE, RSP_VALID});
    end
    step();
    n_chk++;
    if ({RSP_VALID, RSP_ERR, RSP_TOUT, PSEL, PENABLE} !== 5'b10000 || RSP_RDATA !== '0) begin
      n_fail++; $display("FAIL write_resp: got %b rdata %h exp 10000 rdata 0",
                         {RSP_VALID, RSP_ERR, RSP_TOUT, PSEL, PENABLE}, RSP_RDATA);
    end
    drain();
    n_chk++;
    if ({RSP_VALID, CMD_READY} !== 2'b01) begin
      n_fail++; $display("FAIL write_done: got %b exp 01", {RSP_VALID, CMD_READY});
    end
  endtask

  task automatic test_read_wait();
    logic ok;
    TOUT_CYC = 16'd10; PREADY = 1'b0; PRDATA = '0;
    issue(1'b0, 32'h0000_0020, 32'h0000_AAAA);
    n_chk++;
    if (PWDATA !== '0) begin n_fail++; $display("FAIL read_pwdata: got %h exp 0", PWDATA); end
    ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      if (!(PSEL && PENABLE && !PWRITE && PADDR == 32'h20 && !RSP_VALID)) ok = 1'b0;
      PREADY = (i == 3);
      PRDATA = (i == 3) ? 32'hDEAD_BEEF : 32'h0;
    end
    n_chk++;
    if (ok !== 1'b1) begin n_fail++; $display("FAIL read_access_stable: got %b exp 1", ok); end
    step();
    PREADY = 1'b0;
    n_chk++;
    if ({RSP_VALID, RSP_ERR, RSP_TOUT} !== 3'b100 || RSP_RDATA !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL read_resp: got %b %h exp 100 deadbeef",
                         {RSP_VALID, RSP_ERR, RSP_TOUT}, RSP_RDATA);
    end
    drain();
    PRDATA = '0;
  endtask

  task automatic test_slverr();
    TOUT_CYC = '0; PREADY = 1'b1; PSLVERR = 1'b1; PRDATA = 32'hFFFF_FFFF;
    issue(1'b0, 32'h0000_0008, 32'h0);
    step();
    step();
    n_chk++;
    if ({RSP_VALID, RSP_ERR, RSP_TOUT} !== 3'b110 || RSP_RDATA !== '0) begin
      n_fail++; $display("FAIL slverr_resp: got %b %h exp 110 0", {RSP_VALID, RSP_ERR, RSP_TOUT}, RSP_RDATA);
    end
    drain();
    PSLVERR = 1'b0; PRDATA = '0; PREADY = 1'b0;
  endtask

  task automatic test_timeout();
    logic ok;
    // Limit 5, slave never ready: five ACCESS cycles then abort.
    TOUT_CYC = 16'd5; PREADY = 1'b0;
    issue(1'b0, 32'h0000_0010, 32'h0);
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      if (!(PSEL && PENABLE && !RSP_VALID)) ok = 1'b0;
    end
    n_chk++;
    if (ok !== 1'b1) begin n_fail++; $display("FAIL tout5_access_len: got %b exp 1", ok); end
    step();
    n_chk++;
    if ({PSEL, PENABLE, RSP_VALID, RSP_ERR, RSP_TOUT} !== 5'b00111 || RSP_RDATA !== '0) begin
      n_fail++; $display("FAIL tout5_resp: got %b %h exp 00111 0",
                         {PSEL, PENABLE, RSP_VALID, RSP_ERR, RSP_TOUT}, RSP_RDATA);
    end
    drain();

    // Limit 1: abort after the first waited ACCESS cycle.
    TOUT_CYC = 16'd1;
    issue(1'b0, 32'h0000_0014, 32'h0);
    step();
    step();
    n_chk++;
    if ({RSP_VALID, RSP_ERR, RSP_TOUT} !== 3'b111) begin
      n_fail++; $display("FAIL tout1_resp: got %b exp 111", {RSP_VALID, RSP_ERR, RSP_TOUT});
    end
    drain();

    // Limit 2, PREADY arrives on the cycle the limit would be hit: completion wins.
    TOUT_CYC = 16'd2; PRDATA = 32'h0000_00C3;
    issue(1'b0, 32'h0000_0018, 32'h0);
    step();
    step();
    PREADY = 1'b1;
    step();
    PREADY = 1'b0;
    n_chk++;
    if ({RSP_VALID, RSP_ERR, RSP_TOUT} !== 3'b100 || RSP_RDATA !== 32'hC3) begin
      n_fail++; $display("FAIL tout_race_resp: got %b %h exp 100 c3", {RSP_VALID, RSP_ERR, RSP_TOUT}, RSP_RDATA);
    end
    drain();

    // Timeout disabled: a 100-cycle stall still completes normally.
    TOUT_CYC = '0; PRDATA = 32'h5A5A_5A5A;
    issue(1'b0, 32'h0000_001C, 32'h0);
    ok = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step();
      if (!(PSEL && PENABLE && !RSP_VALID)) ok = 1'b0;
    end
    n_chk++;
    if (ok !== 1'b1) begin n_fail++; $display("FAIL tout0_stall: got %b exp 1", ok); end
    PREADY = 1'b1;
    step();
    PREADY = 1'b0;
    n_chk++;
    if ({RSP_VALID, RSP_ERR, RSP_TOUT} !== 3'b100 || RSP_RDATA !== 32'h5A5A_5A5A) begin
      n_fail++; $display("FAIL tout0_resp: got %b %h exp 100 5a5a5a5a", {RSP_VALID, RSP_ERR, RSP_TOUT}, RSP_RDATA);
    end
    drain();
    PRDATA = '0;
  endtask

  task automatic test_back_to_back();
    logic ok;
    int   t[3];
    int   nt;
    bit   done;
    TOUT_CYC = '0; PREADY = 1'b1; PRDATA = 32'h0000_0077;
    issue(1'b0, 32'h0000_0030, 32'h0);
    step();
    step();
    // Response pending, new command waiting, consumer stalled for 4 cycles.
    CMD_VALID = 1'b1; CMD_WRITE = 1'b1; CMD_ADDR = 32'h40; CMD_WDATA = 32'h2;
    ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (!(RSP_VALID && !CMD_READY && !PSEL && RSP_RDATA == 32'h77 && !RSP_ERR)) ok = 1'b0;
      step();
    end
    n_chk++;
    if (ok !== 1'b1) begin n_fail++; $display("FAIL backpressure_hold: got %b exp 1", ok); end
    RSP_READY = 1'b1;
    nt = 0;
    for (int c = 0; c < 12; c++) begin
      if (RSP_VALID && nt < 3) begin t[nt] = c; nt++; end
      step();
    end
    n_chk++;
    if (nt !== 3) begin n_fail++; $display("FAIL b2b_count: got %0d exp 3", nt); end
    else begin
      n_chk++;
      if (t[1] - t[0] !== 4 || t[2] - t[1] !== 4) begin
        n_fail++; $display("FAIL b2b_period: got %0d %0d exp 4 4", t[1] - t[0], t[2] - t[1]);
      end
    end
    CMD_VALID = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 10 && !done; i++) begin
      if (CMD_READY && !RSP_VALID) done = 1'b1;
      else step();
    end
    n_chk++;
    if (done !== 1'b1) begin n_fail++; $display("FAIL b2b_drain: got %b exp 1", done); end
    RSP_READY = 1'b0; PREADY = 1'b0; PRDATA = '0;
  endtask

  task automatic test_reset_mid();
    TOUT_CYC = '0; PREADY = 1'b0;
    issue(1'b1, 32'h0000_0050, 32'h0000_9999);
    step();
    step();
    n_chk++;
    if ({PSEL, PENABLE} !== 2'b11) begin n_fail++; $display("FAIL midrst_pre: got %b exp 11", {PSEL, PENABLE}); end
    #2;
    PRESETn = 1'b0;
    #1;
    n_chk++;
    if (all_o !== '0) begin n_fail++; $display("FAIL midrst_async: got %h exp 0", all_o); end
    step();
    PRESETn = 1'b1;
    step();
    n_chk++;
    if ({CMD_READY, PSEL, RSP_VALID} !== 3'b100) begin
      n_fail++; $display("FAIL midrst_release: got %b exp 100", {CMD_READY, PSEL, RSP_VALID});
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_wait();
    test_slverr();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
